// File: rtl/memory_access_unit.sv
// Memory stage: word load/store over a req/ack bus with stall and timeout.
// Retires pc/isn/result to the memory/writeback register with error flags.
module memory_access_unit #(
   parameter logic [5:0] OPCODE_LOAD    = 6'b100011,
   parameter logic [5:0] OPCODE_STORE   = 6'b101011,
   parameter int         TIMEOUT_CYCLES = 16
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [31:0] pcin,
   input  logic [31:0] isnin,
   input  logic [31:0] resultin,
   input  logic [31:0] operandBin,
   input  logic        validin,
   output logic        stall,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic        mem_ack,
   input  logic [31:0] mem_rdata,
   output logic [31:0] pcout,
   output logic [31:0] isnout,
   output logic [31:0] resultout,
   output logic        validout,
   output logic        misaligned,
   output logic        buserror
);

   localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

   typedef enum logic {
      ST_IDLE,
      ST_WAIT
   } state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          mem_req_q, mem_req_d;
   logic          mem_we_q, mem_we_d;
   logic [31:0]   mem_addr_q, mem_addr_d;
   logic [31:0]   mem_wdata_q, mem_wdata_d;
   logic [31:0]   pc_lat_q, pc_lat_d;
   logic [31:0]   isn_lat_q, isn_lat_d;
   logic [31:0]   pcout_q, pcout_d;
   logic [31:0]   isnout_q, isnout_d;
   logic [31:0]   resultout_q, resultout_d;
   logic          validout_q, validout_d;
   logic          misaligned_q, misaligned_d;
   logic          buserror_q, buserror_d;

   logic [5:0] opcode;
   logic       is_load;
   logic       is_store;
   logic       memop;
   logic       aligned;
   logic       timeout_hit;

   always_comb begin
      opcode      = isnin[31:26];
      is_load     = (opcode == OPCODE_LOAD);
      is_store    = (opcode == OPCODE_STORE);
      memop       = validin & (is_load | is_store);
      aligned     = (resultin[1:0] == 2'b00);
      timeout_hit = (state_q == ST_WAIT) && (cnt_q == CNT_LAST);

      // Gated by reset so an abandoned transaction never holds upstream.
      stall = reset &
              (((state_q == ST_IDLE) & memop & aligned) |
               ((state_q == ST_WAIT) & ~mem_ack & ~timeout_hit));
   end

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      mem_req_d    = mem_req_q;
      mem_we_d     = mem_we_q;
      mem_addr_d   = mem_addr_q;
      mem_wdata_d  = mem_wdata_q;
      pc_lat_d     = pc_lat_q;
      isn_lat_d    = isn_lat_q;
      pcout_d      = pcout_q;
      isnout_d     = isnout_q;
      resultout_d  = resultout_q;
      validout_d   = validout_q;
      misaligned_d = misaligned_q;
      buserror_d   = buserror_q;

      unique case (state_q)
         ST_IDLE: begin
            if (!validin) begin
               validout_d = 1'b0;
            end else if (memop && aligned) begin
               mem_req_d   = 1'b1;
               mem_we_d    = is_store;
               mem_addr_d  = resultin;
               mem_wdata_d = operandBin;
               pc_lat_d    = pcin;
               isn_lat_d   = isnin;
               cnt_d       = '0;
               validout_d  = 1'b0;
               state_d     = ST_WAIT;
            end else begin
               pcout_d      = pcin;
               isnout_d     = isnin;
               resultout_d  = resultin;
               validout_d   = 1'b1;
               misaligned_d = memop;
               buserror_d   = 1'b0;
            end
         end
         ST_WAIT: begin
            if (mem_ack) begin
               mem_req_d    = 1'b0;
               validout_d   = 1'b1;
               pcout_d      = pc_lat_q;
               isnout_d     = isn_lat_q;
               resultout_d  = mem_we_q ? mem_addr_q : mem_rdata;
               misaligned_d = 1'b0;
               buserror_d   = 1'b0;
               state_d      = ST_IDLE;
            end else if (timeout_hit) begin
               mem_req_d    = 1'b0;
               validout_d   = 1'b1;
               pcout_d      = pc_lat_q;
               isnout_d     = isn_lat_q;
               resultout_d  = '0;
               misaligned_d = 1'b0;
               buserror_d   = 1'b1;
               state_d      = ST_IDLE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q      <= ST_IDLE;
         cnt_q        <= '0;
         mem_req_q    <= 1'b0;
         mem_we_q     <= 1'b0;
         mem_addr_q   <= '0;
         mem_wdata_q  <= '0;
         pc_lat_q     <= '0;
         isn_lat_q    <= '0;
         pcout_q      <= '0;
         isnout_q     <= '0;
         resultout_q  <= '0;
         validout_q   <= 1'b0;
         misaligned_q <= 1'b0;
         buserror_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         mem_req_q    <= mem_req_d;
         mem_we_q     <= mem_we_d;
         mem_addr_q   <= mem_addr_d;
         mem_wdata_q  <= mem_wdata_d;
         pc_lat_q     <= pc_lat_d;
         isn_lat_q    <= isn_lat_d;
         pcout_q      <= pcout_d;
         isnout_q     <= isnout_d;
         resultout_q  <= resultout_d;
         validout_q   <= validout_d;
         misaligned_q <= misaligned_d;
         buserror_q   <= buserror_d;
      end
   end

   assign mem_req    = mem_req_q;
   assign mem_we     = mem_we_q;
   assign mem_addr   = mem_addr_q;
   assign mem_wdata  = mem_wdata_q;
   assign pcout      = pcout_q;
   assign isnout     = isnout_q;
   assign resultout  = resultout_q;
   assign validout   = validout_q;
   assign misaligned = misaligned_q;
   assign buserror   = buserror_q;

endmodule

// File: tb/tb_memory_access_unit.sv
// Randomized bench for memory_access_unit against a per-instruction
// transaction model (retire record, stall length, bus fields).
module tb_memory_access_unit;

   localparam logic [5:0] LD_OP = 6'b100011;
   localparam logic [5:0] ST_OP = 6'b101011;
   localparam int TO = 16;

   logic        clock = 1'b0;
   logic        reset;
   logic [31:0] pcin, isnin, resultin, operandBin;
   logic        validin;
   logic        stall;
   logic        mem_req, mem_we;
   logic [31:0] mem_addr, mem_wdata;
   logic        mem_ack;
   logic [31:0] mem_rdata;
   logic [31:0] pcout, isnout, resultout;
   logic        validout, misaligned, buserror;

   int n_chk = 0;
   int n_pass = 0;

   memory_access_unit #(
      .OPCODE_LOAD    (LD_OP),
      .OPCODE_STORE   (ST_OP),
      .TIMEOUT_CYCLES (TO)
   ) dut (
      .clock      (clock),
      .reset      (reset),
      .pcin       (pcin),
      .isnin      (isnin),
      .resultin   (resultin),
      .operandBin (operandBin),
      .validin    (validin),
      .stall      (stall),
      .mem_req    (mem_req),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_ack    (mem_ack),
      .mem_rdata  (mem_rdata),
      .pcout      (pcout),
      .isnout     (isnout),
      .resultout  (resultout),
      .validout   (validout),
      .misaligned (misaligned),
      .buserror   (buserror)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   function automatic logic [31:0] mk_isn(input logic [5:0] op);
      logic [31:0] v;
      v = $urandom;
      v[31:26] = op;
      return v;
   endfunction

   // One instruction from issue to retire. dly = WAIT cycle index on
   // which ack arrives; dly >= TO means no ack at all.
   task automatic run_insn(input logic [31:0] pc, input logic [31:0] isn,
                           input logic [31:0] res, input logic [31:0] opb,
                           input int dly);
      logic        st, memop, mis, tmo;
      logic [31:0] rd, exp_res;
      int          w, nst;
      bit          done;
      st    = (isn[31:26] == ST_OP);
      memop = st || (isn[31:26] == LD_OP);
      mis   = (res[1:0] != 2'b00);
      pcin = pc; isnin = isn; resultin = res; operandBin = opb;
      validin = 1'b1; mem_ack = 1'b0;
      #1;
      if (!memop || mis) begin
         check("stall_pass", stall, 0);
         @(posedge clock); #1;
         check("req_pass", mem_req, 0);
         check("valid_pass", validout, 1);
         check("pc_pass", pcout, pc);
         check("isn_pass", isnout, isn);
         check("res_pass", resultout, res);
         check("mis_pass", misaligned, memop && mis);
         check("berr_pass", buserror, 0);
      end else begin
         check("stall_issue", stall, 1);
         nst = 1;
         @(posedge clock); #1;
         check("valid_issue", validout, 0);
         rd = $urandom;
         w = 0;
         done = 0;
         while (!done) begin
            check("req_wait", mem_req, 1);
            check("we_wait", mem_we, st);
            check("addr_wait", mem_addr, res);
            if (st) check("wdata_wait", mem_wdata, opb);
            mem_ack   = (w == dly);
            mem_rdata = mem_ack ? rd : $urandom;
            validin   = $urandom;
            isnin     = $urandom;
            resultin  = $urandom;
            #1;
            if (stall) nst++;
            done = mem_ack || (w == TO - 1);
            @(posedge clock); #1;
            mem_ack = 1'b0;
            w++;
         end
         tmo = (dly >= TO);
         exp_res = tmo ? 32'h0 : (st ? res : rd);
         check("stall_len", nst, tmo ? TO : dly + 1);
         check("req_done", mem_req, 0);
         check("valid_done", validout, 1);
         check("pc_done", pcout, pc);
         check("isn_done", isnout, isn);
         check("res_done", resultout, exp_res);
         check("berr_done", buserror, tmo);
         check("mis_done", misaligned, 0);
      end
      validin = 1'b0;
   endtask

   task automatic idle_cycle();
      validin = 1'b0;
      isnin = mk_isn(LD_OP);
      resultin = {$urandom} & 32'hFFFF_FFFC;
      #1;
      check("stall_idle", stall, 0);
      @(posedge clock); #1;
      check("valid_idle", validout, 0);
   endtask

   initial begin
      logic [5:0]  op;
      logic [31:0] a;
      int          sel, d;
      reset = 1'b0;
      pcin = 0; isnin = 0; resultin = 0; operandBin = 0;
      validin = 0; mem_ack = 0; mem_rdata = 0;
      repeat (2) @(posedge clock);
      #1;
      isnin = mk_isn(LD_OP); resultin = 32'h40; validin = 1'b1;
      #1;
      check("rst_stall", stall, 0);
      check("rst_req", mem_req, 0);
      check("rst_valid", validout, 0);
      check("rst_res", resultout, 0);
      check("rst_berr", buserror, 0);
      check("rst_mis", misaligned, 0);
      validin = 1'b0;
      reset = 1'b1;

      run_insn(32'h10, mk_isn(6'h00), 32'h1234, 32'h0, 0);
      run_insn(32'h14, mk_isn(LD_OP), 32'h100, 32'h0, 3);
      run_insn(32'h18, mk_isn(ST_OP), 32'h200, 32'hA5A5A5A5, 0);
      run_insn(32'h1C, mk_isn(LD_OP), 32'h102, 32'h0, 0);
      run_insn(32'h20, mk_isn(ST_OP), 32'h203, 32'h1, 0);
      run_insn(32'h24, mk_isn(LD_OP), 32'h300, 32'h0, 1000);
      run_insn(32'h28, mk_isn(LD_OP), 32'h304, 32'h0, TO - 1);
      run_insn(32'h2C, mk_isn(ST_OP), 32'h308, 32'h77, TO - 2);
      idle_cycle();

      // Reset dropped mid-transaction with a memop still presented.
      pcin = 32'h40; isnin = mk_isn(LD_OP); resultin = 32'h400;
      validin = 1'b1;
      @(posedge clock); #1;
      @(posedge clock); #1;
      check("mid_req_pre", mem_req, 1);
      reset = 1'b0;
      #1;
      check("mid_req", mem_req, 0);
      check("mid_valid", validout, 0);
      check("mid_stall", stall, 0);
      #2;
      reset = 1'b1;
      run_insn(32'h44, mk_isn(6'h08), 32'h55AA, 32'h0, 0);

      for (int i = 0; i < 150; i++) begin
         sel = $urandom_range(0, 4);
         op  = (sel == 0) ? LD_OP : (sel == 1) ? ST_OP : 6'($urandom);
         a   = $urandom;
         if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
         d = ($urandom_range(0, 7) == 0) ? $urandom_range(TO - 2, TO + 1)
                                        : $urandom_range(0, 5);
         run_insn($urandom, mk_isn(op), a, $urandom, d);
         if ($urandom_range(0, 3) == 0) idle_cycle();
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule
